oled_cmd_receiver: RTL and testbench

Bit-serial receiver and command decoder for the 4-wire OLED command link (CS/D_C/DIN clocked by OLED_CLK) produced by the OLED driver. It deserialises the MSB-first stream into bytes and parses SSD1331-style opcodes with their argument bytes. It also tracks display/scroll state and reports completed commands on a parallel port. It sits at the panel end of the link: on-board as a protocol monitor, and in simulation as the checker for the driver.

---
 rtl/oled_cmd_receiver.sv | 146 ++++++++++++++
 tb/tb_oled_cmd_receiver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_cmd_receiver.sv
`default_nettype none
// =============================================================================
// oled_cmd_receiver : bit-serial OLED link deserialiser and SSD1331 command decoder
// Revision 1.0
// =============================================================================
module oled_cmd_receiver (
   input  logic        OLED_CLK,
   input  logic        RESET,
   input  logic        OLED_RES,
   input  logic        OLED_CS,
   input  logic        OLED_D_C,
   input  logic        OLED_DIN,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_is_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_opcode,
   output logic [79:0] cmd_args,
   output logic [3:0]  cmd_nargs,
   output logic        cmd_unknown,
   output logic        display_on,
   output logic        scroll_active,
   output logic [1:0]  err,
   output logic [15:0] cmd_count
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ARGS = 1'b1} state_t;

   state_t      r_state;
   // Seven stored bits suffice: the eighth is taken straight from DIN on the completing edge.
   logic [6:0]  r_shift;
   logic [2:0]  r_bit_cnt;
   logic [3:0]  r_arg_idx;
   logic [3:0]  r_arg_need;
   logic [7:0]  r_op;
   logic [79:0] r_args;

   logic        w_rst;
   logic [7:0]  w_byte;
   logic [3:0]  w_nargs;
   logic        w_known;
   logic [6:0]  w_arg_shift;
   logic [79:0] w_args_next;

   assign w_rst       = ~RESET | ~OLED_RES;
   assign w_byte      = {r_shift, OLED_DIN};
   assign w_arg_shift = 7'd72 - {r_arg_idx, 3'b000};
   assign w_args_next = r_args | ({72'd0, w_byte} << w_arg_shift);

   always_comb begin
      w_known = 1'b1;
      w_nargs = 4'd0;
      case (w_byte)
         8'h21: w_nargs = 4'd7;
         8'h22: w_nargs = 4'd10;
         8'h25: w_nargs = 4'd4;
         8'h27: w_nargs = 4'd5;
         8'h26, 8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0,
         8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE:
            w_nargs = 4'd1;
         8'h2E, 8'h2F, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAE, 8'hAF, 8'hE3:
            w_nargs = 4'd0;
         default: w_known = 1'b0;
      endcase
   end

   always_ff @(posedge OLED_CLK) begin
      if (w_rst) begin
         r_state       <= S_IDLE;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_arg_idx     <= '0;
         r_arg_need    <= '0;
         r_op          <= '0;
         r_args        <= '0;
         byte_valid    <= 1'b0;
         byte_data     <= '0;
         byte_is_data  <= 1'b0;
         cmd_valid     <= 1'b0;
         cmd_opcode    <= '0;
         cmd_args      <= '0;
         cmd_nargs     <= '0;
         cmd_unknown   <= 1'b0;
         display_on    <= 1'b0;
         scroll_active <= 1'b0;
         err           <= '0;
         cmd_count     <= '0;
      end else begin
         byte_valid <= 1'b0;
         cmd_valid  <= 1'b0;
         if (!OLED_CS) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               byte_valid   <= 1'b1;
               byte_data    <= w_byte;
               byte_is_data <= OLED_D_C;
               if (r_state == S_IDLE) begin
                  if (!OLED_D_C) begin
                     if (w_nargs == 4'd0) begin
                        cmd_valid   <= 1'b1;
                        cmd_opcode  <= w_byte;
                        cmd_args    <= '0;
                        cmd_nargs   <= 4'd0;
                        cmd_unknown <= ~w_known;
                        cmd_count   <= cmd_count + 16'd1;
                        if (w_byte == 8'hAF) display_on    <= 1'b1;
                        if (w_byte == 8'hAE) display_on    <= 1'b0;
                        if (w_byte == 8'h2F) scroll_active <= 1'b1;
                        if (w_byte == 8'h2E) scroll_active <= 1'b0;
                     end else begin
                        r_state    <= S_ARGS;
                        r_op       <= w_byte;
                        r_arg_need <= w_nargs;
                        r_arg_idx  <= 4'd0;
                        r_args     <= '0;
                     end
                  end
               end else if (OLED_D_C) begin
                  err[1]  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_args    <= w_args_next;
                  r_arg_idx <= r_arg_idx + 4'd1;
                  if (r_arg_idx + 4'd1 == r_arg_need) begin
                     cmd_valid   <= 1'b1;
                     cmd_opcode  <= r_op;
                     cmd_args    <= w_args_next;
                     cmd_nargs   <= r_arg_need;
                     cmd_unknown <= 1'b0;
                     cmd_count   <= cmd_count + 16'd1;
                     r_state     <= S_IDLE;
                  end
               end
            end
         end else if (r_bit_cnt != 3'd0) begin
            // CS released mid-byte: drop the partial byte and any command in flight.
            r_bit_cnt <= 3'd0;
            err[0]    <= 1'b1;
            r_state   <= S_IDLE;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_oled_cmd_receiver.sv
`default_nettype none
// Bench for oled_cmd_receiver: transaction-level model compared every cycle, plus literal pins.
module tb_oled_cmd_receiver;

   logic        OLED_CLK = 1'b0;
   logic        RESET = 1'b0, OLED_RES = 1'b1, OLED_CS = 1'b1, OLED_D_C = 1'b0, OLED_DIN = 1'b0;
   logic        byte_valid, byte_is_data, cmd_valid, cmd_unknown, display_on, scroll_active;
   logic [7:0]  byte_data, cmd_opcode;
   logic [79:0] cmd_args;
   logic [3:0]  cmd_nargs;
   logic [1:0]  err;
   logic [15:0] cmd_count;

   oled_cmd_receiver dut (
      .OLED_CLK(OLED_CLK), .RESET(RESET), .OLED_RES(OLED_RES), .OLED_CS(OLED_CS),
      .OLED_D_C(OLED_D_C), .OLED_DIN(OLED_DIN), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_is_data(byte_is_data), .cmd_valid(cmd_valid),
      .cmd_opcode(cmd_opcode), .cmd_args(cmd_args), .cmd_nargs(cmd_nargs),
      .cmd_unknown(cmd_unknown), .display_on(display_on), .scroll_active(scroll_active),
      .err(err), .cmd_count(cmd_count)
   );

   always #5 OLED_CLK = ~OLED_CLK;

   int errors = 0;
   int checks = 0;

   // Model state: expected outputs plus the command being assembled.
   logic        m_bv, m_bid, m_cv, m_unk, m_disp, m_scr;
   logic [7:0]  m_bd, m_op;
   logic [79:0] m_args;
   logic [3:0]  m_nargs;
   logic [1:0]  m_err;
   logic [15:0] m_cnt;
   bit          m_busy;
   int          m_need;
   int          m_bits;
   logic [7:0]  m_pend_op;
   logic [7:0]  m_q[$];
   logic [7:0]  cur_tx;

   function automatic int model_nargs(input logic [7:0] op);
      case (op)
         8'h21: return 7;
         8'h22: return 10;
         8'h25: return 4;
         8'h27: return 5;
         8'h26, 8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0,
         8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE: return 1;
         8'h2E, 8'h2F, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAE, 8'hAF, 8'hE3: return 0;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_bv = 0; m_bid = 0; m_cv = 0; m_unk = 0; m_disp = 0; m_scr = 0;
      m_bd = 0; m_op = 0; m_args = 0; m_nargs = 0; m_err = 0; m_cnt = 0;
      m_busy = 0; m_need = 0; m_bits = 0; m_pend_op = 0;
      m_q.delete();
   endtask

   task automatic model_complete(input logic [7:0] op, input bit unknown);
      m_cv    = 1;
      m_op    = op;
      m_args  = '0;
      foreach (m_q[k]) m_args[79 - 8*k -: 8] = m_q[k];
      m_nargs = 4'(m_q.size());
      m_unk   = unknown;
      m_cnt   = m_cnt + 16'd1;
      if (op == 8'hAF) m_disp = 1;
      if (op == 8'hAE) m_disp = 0;
      if (op == 8'h2F) m_scr = 1;
      if (op == 8'h2E) m_scr = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic dc);
      int n;
      m_bv = 1; m_bd = b; m_bid = dc;
      if (!m_busy) begin
         if (!dc) begin
            n = model_nargs(b);
            m_q.delete();
            if (n <= 0) model_complete(b, n < 0);
            else begin
               m_busy = 1; m_pend_op = b; m_need = n;
            end
         end
      end else if (dc) begin
         m_err[1] = 1; m_busy = 0;
      end else begin
         m_q.push_back(b);
         if (m_q.size() == m_need) begin
            model_complete(m_pend_op, 0);
            m_busy = 0;
         end
      end
   endtask

   task automatic model_edge(input logic cs, input logic dc, input logic rst_ok);
      m_bv = 0; m_cv = 0;
      if (!rst_ok) model_reset();
      else if (!cs) begin
         m_bits++;
         if (m_bits == 8) begin
            m_bits = 0;
            model_byte(cur_tx, dc);
         end
      end else if (m_bits != 0) begin
         m_bits = 0; m_err[0] = 1; m_busy = 0;
      end
   endtask

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("byte_valid", 80'(byte_valid), 80'(m_bv));
      chk("byte_data", 80'(byte_data), 80'(m_bd));
      chk("byte_is_data", 80'(byte_is_data), 80'(m_bid));
      chk("cmd_valid", 80'(cmd_valid), 80'(m_cv));
      chk("cmd_opcode", 80'(cmd_opcode), 80'(m_op));
      chk("cmd_args", cmd_args, m_args);
      chk("cmd_nargs", 80'(cmd_nargs), 80'(m_nargs));
      chk("cmd_unknown", 80'(cmd_unknown), 80'(m_unk));
      chk("display_on", 80'(display_on), 80'(m_disp));
      chk("scroll_active", 80'(scroll_active), 80'(m_scr));
      chk("err", 80'(err), 80'(m_err));
      chk("cmd_count", 80'(cmd_count), 80'(m_cnt));
   endtask

   task automatic clk_edge(input logic cs, input logic dc, input logic din,
                           input logic rst_n, input logic res_n);
      OLED_CS = cs; OLED_D_C = dc; OLED_DIN = din; RESET = rst_n; OLED_RES = res_n;
      @(posedge OLED_CLK);
      #1;
      model_edge(cs, dc, rst_n & res_n);
      compare_all();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc);
      cur_tx = b;
      for (int i = 0; i < 8; i++) clk_edge(1'b0, dc, b[7-i], 1'b1, 1'b1);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      cur_tx = b;
      for (int i = 0; i < n; i++) clk_edge(1'b0, 1'b0, b[7-i], 1'b1, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) clk_edge(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic do_reset();
      clk_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      clk_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] line_seq [8]  = '{8'h21, 8'h0C, 8'h0A, 8'h0C, 8'h18, 8'h3F, 8'h00, 8'h00};
      logic [7:0] init_seq [38] = '{8'h2E, 8'hAE, 8'hA0, 8'h74, 8'hA1, 8'h00, 8'hA2, 8'h00,
                                    8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1,
                                    8'h31, 8'hB3, 8'hF0, 8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C,
                                    8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06, 8'h81,
                                    8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'hAF};
      model_reset();
      cur_tx = 8'h00;
      do_reset();
      chk("reset_count", 80'(cmd_count), 80'd0);
      idle(2);

      // Single zero-argument opcode
      send_byte(8'hAF, 1'b0);
      chk("t1_byte_data", 80'(byte_data), 80'hAF);
      chk("t1_cmd_valid", 80'(cmd_valid), 80'd1);
      idle(2);
      chk("t1_display_on", 80'(display_on), 80'd1);
      chk("t1_count", 80'(cmd_count), 80'd1);

      // Seven-argument line in one CS burst
      foreach (line_seq[i]) send_byte(line_seq[i], 1'b0);
      chk("line_args", cmd_args, {56'h0C0A0C183F0000, 24'h0});
      chk("line_model_args", m_args, {56'h0C0A0C183F0000, 24'h0});
      chk("line_nargs", 80'(cmd_nargs), 80'd7);
      idle(1);

      // Full init stream from a clean state
      do_reset();
      foreach (init_seq[i]) send_byte(init_seq[i], 1'b0);
      idle(2);
      chk("init_count", 80'(cmd_count), 80'd21);
      chk("init_model_count", 80'(m_cnt), 80'd21);
      chk("init_display", 80'(display_on), 80'd1);
      chk("init_scroll", 80'(scroll_active), 80'd0);
      chk("init_err", 80'(err), 80'd0);

      // Framing error on a 5-bit fragment, then a clean 0x2F
      send_bits(8'hA5, 5);
      idle(1);
      chk("frame_err", 80'(err), 80'd1);
      send_byte(8'h2F, 1'b0);
      idle(1);
      chk("frame_scroll", 80'(scroll_active), 80'd1);

      // Data byte inside argument collection
      send_byte(8'h25, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h55, 1'b1);
      chk("proto_is_data", 80'(byte_is_data), 80'd1);
      chk("proto_cmd_valid", 80'(cmd_valid), 80'd0);
      chk("proto_err", 80'(err), 80'd3);
      send_byte(8'hAE, 1'b0);
      chk("proto_recover_op", 80'(cmd_opcode), 80'hAE);
      idle(1);
      chk("proto_display", 80'(display_on), 80'd0);

      // Unknown opcode and a one-argument command back to back
      send_byte(8'h55, 1'b0);
      chk("unknown_flag", 80'(cmd_unknown), 80'd1);
      send_byte(8'h26, 1'b0);
      send_byte(8'h01, 1'b0);
      chk("fill_args", cmd_args, {8'h01, 72'h0});
      chk("fill_known", 80'(cmd_unknown), 80'd0);
      idle(1);

      // Reset in the middle of a rectangle command
      send_byte(8'h22, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      idle(1);
      clk_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_count", 80'(cmd_count), 80'd0);
      chk("rst_err", 80'(err), 80'd0);
      chk("rst_scroll", 80'(scroll_active), 80'd0);
      send_byte(8'hAE, 1'b0);
      chk("rst_op", 80'(cmd_opcode), 80'hAE);
      chk("rst_new_count", 80'(cmd_count), 80'd1);
      idle(1);

      // Panel reset mid-byte while CS stays low, then a fresh opcode
      send_bits(8'hFF, 3);
      clk_edge(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_byte(8'hA4, 1'b0);
      chk("res_count", 80'(cmd_count), 80'd1);
      chk("res_op", 80'(cmd_opcode), 80'hA4);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
